sync_fifo_flags: RTL
====================

Name: sync_fifo_flags

Overview:
- Parametrised single-clock FIFO. It is the next-generation replacement for the team's basic FIFO.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and a selectable read mode: registered read or first-word-fall-through (FWFT).
- Sits between producer and consumer datapaths in the same clock domain, for example UART RX to the parser, or the command queue to the executor.

Parameters:
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 1..10.
- DATA_WIDTH, 8: word width in bits.
- FWFT, 0: 0 = registered read mode; 1 = first-word-fall-through mode.
- AF_THRESH, 2**ADDR_WIDTH-1: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky error flag; present only with FIFO_ERR_FLAGS_EN.
- underflow  out  1  sticky error flag; present only with FIFO_ERR_FLAGS_EN.
- err_clr  in  1  clears both sticky flags; present only with FIFO_ERR_FLAGS_EN.

Behaviour:
- Reset (rst_n low, asynchronous assert): pointers = 0, count = 0, dout = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless AF_THRESH = 0, which is illegal), overflow = underflow = 0.
- Reset release is synchronous; the first accepted write is on the first rising edge with rst_n high.
- Reset mid-operation discards all contents. Memory contents need not be cleared.
- Flags and count are registered and derived from the post-edge count. No combinational path from wr_en/rd_en to any flag.
- Storage: DEPTH x DATA_WIDTH array; wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH.
- Write accepted = wr_en & (!full | rd_accepted).
- Read accepted = rd_en & !empty.
- Simultaneous accepted read and write: count unchanged. When full, the read frees the slot the write uses in the same edge.
- Write while full with no read: dropped; pointers and count unchanged.
- Read while empty: ignored; dout holds; count stays 0.
- Read and write while empty: only the write is accepted. count becomes 1, and dout is not updated by the write in that cycle.
- FWFT = 0 (registered read): on an accepted read, dout <= mem[rd_ptr] at that edge, so data is valid 1 cycle after rd_en. dout holds otherwise.
- FWFT = 1: dout shows the head word whenever empty = 0. rd_en acknowledges and pops the head.
  - The head is registered into dout one cycle after a write into an empty FIFO; empty deasserts in that same cycle.
  - After a pop, dout shows the next word on the following cycle, or holds its last value if the FIFO became empty.
  - Implement with a registered output stage counted in count.
- count: increments on write-only, decrements on read-only, saturates naturally at 0..DEPTH.
- Boundary ADDR_WIDTH = 1 (DEPTH = 2) must work in both modes.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on the edge where wr_en = 1 and the write is rejected.
  - underflow sets on the edge where rd_en = 1 and empty = 1.
  - Both flags hold until err_clr = 1 at a rising edge. If a set condition and err_clr coincide, set wins.
- Not defined: the overflow, underflow and err_clr ports and their logic are absent. All other behaviour is identical.

Test Plan (ADDR_WIDTH=2, DATA_WIDTH=8, AF_THRESH=3, AE_THRESH=1):
- Reset, then write 0x11, 0x22, 0x33, 0x44 -> count goes 1, 2, 3, 4. almost_full rises at count = 3; full = 1 at 4; almost_empty falls at count = 2.
- Full, then wr_en = 1 with din = 0x55 and rd_en = 0 -> count stays 4. Contents 0x11..0x44 intact; overflow = 1 (macro on); err_clr for 1 cycle -> overflow = 0.
- Full, then wr_en = rd_en = 1 with din = 0x55 -> count stays 4 and full stays 1. FWFT = 0: dout = 0x11 next cycle. Subsequent drain yields 0x22, 0x33, 0x44, 0x55.
- Empty, then wr_en = rd_en = 1 with din = 0x66 -> count = 1, empty = 0, dout unchanged in FWFT = 0. Next read -> dout = 0x66.
- FWFT = 1: write 0xA5 into an empty FIFO -> next cycle empty = 0 and dout = 0xA5 with no rd_en. rd_en = 1 for 1 cycle -> empty = 1, underflow stays 0. A further rd_en -> underflow = 1.
- Assert rst_n = 0 asynchronously mid-burst with count = 3 -> outputs go to reset values immediately, without waiting for a clock edge. After release, a read -> empty stays 1 and dout = 0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, almost-full/almost-empty flags and
// selectable registered-read or first-word-fall-through output. FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module sync_fifo_flags #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 1,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          out_valid_q, out_valid_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;

    logic          wr_acc;
    logic          rd_acc;
    logic          mem_we;
    logic          mem_empty;

    assign rd_acc = rd_en & ~empty_q;
    assign wr_acc = wr_en & (~full_q | rd_acc);

    // In FWFT mode the output register holds the head word, so memory holds count minus that word.
    assign mem_empty = (count_q == CW'(out_valid_q));

    // Occupancy and flags, all derived from the post-edge count.
    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
        af_d    = (count_d >= CW'(AF_THRESH));
        ae_d    = (count_d <= CW'(AE_THRESH));
    end

    // Pointer, memory-write and output-stage control for both read modes.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        mem_we      = 1'b0;
        if (FWFT == 0) begin
            out_valid_d = 1'b0;
            if (wr_acc) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                dout_d   = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
        end else begin
            if (!out_valid_q || rd_acc) begin
                // Output stage is free this edge: refill from memory, else bypass the incoming word.
                if (!mem_empty) begin
                    dout_d      = mem[rd_ptr_q];
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                    out_valid_d = 1'b1;
                    if (wr_acc) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end else if (wr_acc) begin
                    dout_d      = din;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (wr_acc) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
        end
    end

    // Storage is not reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A set condition in the same edge as err_clr wins.
    always_comb begin
        ovf_d = (ovf_q & ~err_clr) | (wr_en & ~wr_acc);
        unf_d = (unf_q & ~err_clr) | (rd_en & empty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule
